// File: rtl/rf_ctrl_pkg.sv
// ============================================================================
//  Module      : rf_ctrl_pkg
//  Description : Shared defaults and helpers for the register-file write path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_ctrl_pkg;

    localparam int unsigned c_def_nreq   = 3;
    localparam int unsigned c_def_aw     = 5;
    localparam int unsigned c_def_dw     = 32;
    localparam int unsigned c_drop_cnt_w = 16;

    // Saturating increment for the discarded-write counter.
    function automatic logic [c_drop_cnt_w-1:0] f_sat_inc(input logic [c_drop_cnt_w-1:0] v);
        return (v == {c_drop_cnt_w{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage : rf_ctrl_pkg

`default_nettype wire

// File: rtl/rf_write_arbiter_if.sv
// ============================================================================
//  Module      : rf_write_arbiter_if
//  Description : Multi-requester write request bus into the write arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rf_write_arbiter_if
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned NREQ = c_def_nreq,
    parameter int unsigned AW   = c_def_aw,
    parameter int unsigned DW   = c_def_dw
) ();

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               hold;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        output hold,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        input  hold,
        output req_ready
    );

endinterface : rf_write_arbiter_if

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin one-hot arbiter with rotating priority pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic [N-1:0] i_req,
    input  wire logic         i_advance,
    output logic      [N-1:0] o_gnt
);

    localparam int unsigned c_pw = (N > 1) ? $clog2(N) : 1;

    logic [c_pw-1:0] r_ptr;
    logic [N-1:0]    w_hi;
    logic [N-1:0]    w_sel;
    logic [c_pw-1:0] w_idx;

    // Requests at or above the pointer take precedence; otherwise wrap to the bottom.
    always_comb begin
        w_hi = '0;
        for (int i = 0; i < N; i++) begin
            w_hi[i] = i_req[i] && (c_pw'(i) >= r_ptr);
        end
        w_sel = (|w_hi) ? w_hi : i_req;
        o_gnt = '0;
        w_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_sel[i]) begin
                o_gnt    = '0;
                o_gnt[i] = 1'b1;
                w_idx    = c_pw'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (w_idx == c_pw'(N - 1)) ? '0 : w_idx + 1'b1;
        end
    end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/rf_write_arbiter.sv
// ============================================================================
//  Module      : rf_write_arbiter
//  Description : Arbitrates register-file writes from several requesters and
//                provides decode-stage bypass of the in-flight write.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_write_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned NREQ    = c_def_nreq,
    parameter int unsigned AW      = c_def_aw,
    parameter int unsigned DW      = c_def_dw,
    parameter int unsigned ZERO_RO = 1
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    rf_write_arbiter_if.slave            req_if,
    output logic                         rf_we,
    output logic [AW-1:0]                rf_waddr,
    output logic [DW-1:0]                rf_wdata,
    input  wire logic [AW-1:0]           rd_addr1,
    input  wire logic [AW-1:0]           rd_addr2,
    output logic                         byp_hit1,
    output logic                         byp_hit2,
    output logic [DW-1:0]                byp_data1,
    output logic [DW-1:0]                byp_data2,
    output logic [c_drop_cnt_w-1:0]      drop_cnt
);

    localparam bit c_zero_ro = (ZERO_RO != 0);

    logic [NREQ-1:0]         w_req;
    logic [NREQ-1:0]         w_gnt;
    logic                    w_xfer;
    logic                    w_zero;
    logic [AW-1:0]           w_addr;
    logic [DW-1:0]           w_data;

    logic                    r_we;
    logic [AW-1:0]           r_waddr;
    logic [DW-1:0]           r_wdata;
    logic [c_drop_cnt_w-1:0] r_drop_cnt;

    // Hold and reset mask requests before arbitration so no grant can leak out.
    assign w_req  = req_if.req_valid & {NREQ{~req_if.hold & rst_n}};
    assign w_xfer = |w_gnt;

    rr_arbiter #(
        .N (NREQ)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (w_req),
        .i_advance (w_xfer),
        .o_gnt     (w_gnt)
    );

    assign req_if.req_ready = w_gnt;

    always_comb begin
        w_addr = '0;
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_addr = req_if.req_addr[i*AW +: AW];
                w_data = req_if.req_data[i*DW +: DW];
            end
        end
    end

    assign w_zero = c_zero_ro && (w_addr == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_we <= w_xfer && !w_zero;
            if (w_xfer && !w_zero) begin
                r_waddr <= w_addr;
                r_wdata <= w_data;
            end
            if (w_xfer && w_zero) begin
                r_drop_cnt <= f_sat_inc(r_drop_cnt);
            end
        end
    end

    assign rf_we    = r_we;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;
    assign drop_cnt = r_drop_cnt;

    assign byp_hit1  = r_we && (r_waddr == rd_addr1);
    assign byp_hit2  = r_we && (r_waddr == rd_addr2);
    assign byp_data1 = byp_hit1 ? r_wdata : '0;
    assign byp_data2 = byp_hit2 ? r_wdata : '0;

endmodule : rf_write_arbiter

`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
// ============================================================================
//  Module      : tb_rf_write_arbiter
//  Description : Scoreboard bench for rf_write_arbiter with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic        byp_hit1;
    logic        byp_hit2;
    logic [31:0] byp_data1;
    logic [31:0] byp_data2;
    logic [15:0] drop_cnt;

    int tests = 0;
    int fails = 0;
    logic [36:0] exp_q[$];

    rf_write_arbiter_if #(.NREQ(3), .AW(5), .DW(32)) bus ();

    rf_write_arbiter #(
        .NREQ(3), .AW(5), .DW(32), .ZERO_RO(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_if    (bus),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .byp_hit1  (byp_hit1),
        .byp_hit2  (byp_hit2),
        .byp_data1 (byp_data1),
        .byp_data2 (byp_data2),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every register-file write must match the oldest expected write.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {27'd0, rf_waddr, rf_wdata}, 64'd0);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("write_addr", {59'd0, rf_waddr}, {59'd0, e[36:32]});
                chk("write_data", {32'd0, rf_wdata}, {32'd0, e[31:0]});
            end
        end
    end

    task automatic cyc(input logic rst, input logic [2:0] v, input logic h,
                       input logic [14:0] a, input logic [95:0] d,
                       input logic [2:0] exp_rdy, input logic exp_we, input string tag);
        rst_n         = rst;
        bus.req_valid = v;
        bus.hold      = h;
        bus.req_addr  = a;
        bus.req_data  = d;
        @(negedge clk);
        chk({tag, "_ready"}, {61'd0, bus.req_ready}, {61'd0, exp_rdy});
        chk({tag, "_we"}, {63'd0, rf_we}, {63'd0, exp_we});
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                if (exp_rdy[i] && (a[i*5 +: 5] != 5'd0))
                    exp_q.push_back({a[i*5 +: 5], d[i*32 +: 32]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dk;
        rst_n = 1'b0;
        rd_addr1 = '0;
        rd_addr2 = '0;
        bus.req_valid = '0;
        bus.hold = 1'b0;
        bus.req_addr = '0;
        bus.req_data = '0;

        cyc(0, 3'b111, 0, {5'd3, 5'd2, 5'd1}, '0, 3'b000, 0, "in_reset0");
        cyc(0, 3'b111, 0, {5'd3, 5'd2, 5'd1}, '0, 3'b000, 0, "in_reset1");
        cyc(1, 3'b000, 0, '0, '0, 3'b000, 0, "rst_rel");
        chk("rst_waddr", {59'd0, rf_waddr}, 64'd0);
        chk("rst_wdata", {32'd0, rf_wdata}, 64'd0);
        chk("rst_drop", {48'd0, drop_cnt}, 64'd0);
        chk("rst_byp1", {63'd0, byp_hit1}, 64'd0);

        // Single requester
        cyc(1, 3'b010, 0, {5'd0, 5'd7, 5'd0}, {32'd0, 32'hDEADBEEF, 32'd0}, 3'b010, 0, "single");
        cyc(1, 3'b000, 0, '0, '0, 3'b000, 1, "single_wr");
        chk("hold_waddr", {59'd0, rf_waddr}, 64'd7);
        chk("hold_wdata", {32'd0, rf_wdata}, 64'hDEADBEEF);

        // Fairness from a fresh reset
        cyc(0, 3'b000, 0, '0, '0, 3'b000, 0, "rst2");
        for (int k = 0; k < 6; k++) begin
            dk = 32'hA5A5_0000 + k;
            cyc(1, 3'b111, 0, {5'd3, 5'd2, 5'd1}, {dk, dk, dk},
                3'(1 << (k % 3)), (k > 0), "fair");
        end

        // Hold blocks everything, then requester 0 wins
        for (int k = 0; k < 3; k++)
            cyc(1, 3'b111, 1, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 3'b000, (k == 0), "hold");
        cyc(1, 3'b111, 0, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 3'b001, 0, "hold_rel");

        // Address-0 write is accepted and dropped
        chk("drop_before", {48'd0, drop_cnt}, 64'd0);
        cyc(1, 3'b010, 0, '0, {32'd0, 32'h12345678, 32'd0}, 3'b010, 1, "zero");
        cyc(1, 3'b000, 0, '0, '0, 3'b000, 0, "zero_after");
        chk("drop_after", {48'd0, drop_cnt}, 64'd1);

        // Bypass of the in-flight write
        cyc(1, 3'b100, 0, {5'd5, 5'd0, 5'd0}, {32'h55, 32'd0, 32'd0}, 3'b100, 0, "byp");
        rd_addr1 = 5'd5;
        rd_addr2 = 5'd6;
        bus.req_valid = '0;
        @(negedge clk);
        chk("byp_hit1", {63'd0, byp_hit1}, 64'd1);
        chk("byp_data1", {32'd0, byp_data1}, 64'h55);
        chk("byp_hit2", {63'd0, byp_hit2}, 64'd0);
        chk("byp_data2", {32'd0, byp_data2}, 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("byp_hit1_idle", {63'd0, byp_hit1}, 64'd0);
        @(posedge clk);
        #1;
        rd_addr1 = '0;
        rd_addr2 = '0;

        // Reset asserted in the middle of a stream
        cyc(1, 3'b111, 0, {5'd3, 5'd2, 5'd1}, {32'h7003, 32'h7002, 32'h7001}, 3'b001, 0, "mid_xfer");
        cyc(0, 3'b111, 0, {5'd3, 5'd2, 5'd1}, {32'h7003, 32'h7002, 32'h7001}, 3'b000, 1, "mid_rst");
        cyc(1, 3'b111, 0, {5'd3, 5'd2, 5'd1}, {32'h8003, 32'h8002, 32'h8001}, 3'b001, 0, "mid_rel");
        chk("mid_drop", {48'd0, drop_cnt}, 64'd0);
        cyc(1, 3'b000, 0, '0, '0, 3'b000, 1, "mid_wr");
        cyc(1, 3'b000, 0, '0, '0, 3'b000, 0, "idle");

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_rf_write_arbiter

`default_nettype wire

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3: number of write requesters.
REQ-002 SHALL have parameter AW, default 5: register address width.
REQ-003 SHALL have parameter DW, default 32: register data width.
REQ-004 SHALL have parameter ZERO_RO, default 1: 1 means writes to address 0 are accepted and discarded.
REQ-005 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-007 SHALL have port req_valid  in  NREQ  per-requester write request.
REQ-008 SHALL have port req_addr  in  NREQ*AW  per-requester destination address; requester i uses slice [i*AW +: AW].
REQ-009 SHALL have port req_data  in  NREQ*DW  per-requester write data; requester i uses slice [i*DW +: DW].
REQ-010 SHALL have port req_ready  out  NREQ  per-requester grant; at most one bit high.
REQ-011 SHALL have port hold  in  1  blocks all grants while high.
REQ-012 SHALL have port rf_we  out  1  register-file write enable.
REQ-013 SHALL have port rf_waddr  out  AW  register-file write address.
REQ-014 SHALL have port rf_wdata  out  DW  register-file write data.
REQ-015 SHALL have ports rd_addr1 and rd_addr2  in  AW each  decode-stage read addresses.
REQ-016 SHALL have ports byp_hit1 and byp_hit2  out  1 each  in-flight write matches the read address.
REQ-017 SHALL have ports byp_data1 and byp_data2  out  DW each  bypass data.
REQ-018 SHALL have port drop_cnt  out  16  count of discarded address-0 writes.

Function
REQ-019 SHALL transfer a write when req_valid[i] and req_ready[i] are both high on a rising edge.
REQ-020 SHALL drive req_ready combinationally from req_valid, hold and the priority pointer; all bits are 0 when hold=1 or no request is valid.
REQ-021 SHALL grant round-robin: search starts at pointer p and wraps; p=0 after reset; after a transfer from requester i, p becomes (i+1) mod NREQ; p holds when no transfer occurs.
REQ-022 SHALL register the accepted write in the next cycle:
- rf_we=1, rf_waddr=addr, rf_wdata=data.
- Latency is exactly 1 cycle from handshake to rf_we.
REQ-023 SHALL drive rf_we=0 in every cycle that follows a cycle without a transfer; rf_waddr and rf_wdata hold their last values.
REQ-024 SHALL, when ZERO_RO=1 and the accepted address is 0, complete the handshake, keep rf_we=0 and increment drop_cnt; drop_cnt saturates at 16'hFFFF.
REQ-025 SHALL set byp_hitN=1 when rf_we=1 and rf_waddr==rd_addrN (combinational on registered state); byp_dataN=rf_wdata when hit, else 0.
REQ-026 SHALL ignore requesters whose valid is low regardless of pointer position; a requester valid continuously is granted within NREQ transfers.
REQ-027 SHALL require requesters to hold valid, addr and data stable until accepted; the arbiter need not check this.
REQ-028 SHALL accept at most one write per cycle (back-to-back transfers allowed every cycle).

Reset
REQ-029 SHALL, while rst_n=0 at a rising edge: set rf_we=0, rf_waddr=0, rf_wdata=0, p=0, drop_cnt=0.
REQ-030 SHALL drive req_ready=0 during reset; a handshake coincident with reset is discarded, including on reset asserted mid-stream.
REQ-031 SHALL deassert byp_hit1 and byp_hit2 in the first cycle after reset.

Structure
REQ-032 SHALL take NREQ, AW and DW defaults from shared package rf_ctrl_pkg, which also holds the drop-counter width constant.
REQ-033 SHALL place round-robin grant logic and pointer in one sub-module rr_arbiter (request vector in, one-hot grant out, advance input).

Verification
REQ-034 SHALL cover single requester: req_valid=3'b010, addr=7, data=32'hDEADBEEF -> ready[1]=1; next cycle rf_we=1, rf_waddr=7, rf_wdata=DEADBEEF.
REQ-035 SHALL cover fairness: all three valid for 6 cycles from reset -> grant order 0,1,2,0,1,2; rf_we high 6 consecutive cycles.
REQ-036 SHALL cover hold: hold=1 with req_valid=3'b111 for 3 cycles -> req_ready=0, rf_we=0; hold release -> requester 0 granted.
REQ-037 SHALL cover zero write: ZERO_RO=1, addr=0 accepted -> rf_we=0, drop_cnt 0->1.
REQ-038 SHALL cover bypass: write addr=5 data=0x55 accepted, rd_addr1=5 and rd_addr2=6 next cycle -> byp_hit1=1 with byp_data1=0x55; byp_hit2=0.
REQ-039 SHALL cover reset mid-stream: rst_n=0 during a handshake -> rf_we=0 the next cycle; first grant after release goes to requester 0.
